// File: rtl/dap_gpio_bank.sv
// GPIO bank for the DAP controller: output/enable registers, synchronised inputs,
// sticky edge status with interrupt, and a one-shot timed pulse generator.
module dap_gpio_bank #(
  parameter int unsigned ADDRWIDTH   = 12,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned GPIO_NUM    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ahb_write_en,
  input  logic [ADDRWIDTH-1:0] ahb_addr,
  input  logic [31:0]          ahb_wdata,
  input  logic [3:0]           ahb_byte_strobe,
  output logic [31:0]          ahb_rdata,
  input  logic [GPIO_NUM-1:0]  gpio_i,
  output logic [GPIO_NUM-1:0]  gpio_o,
  output logic [GPIO_NUM-1:0]  gpio_oe,
  output logic                 irq
);

  localparam int unsigned G  = GPIO_NUM;
  localparam int unsigned WA = ADDRWIDTH - 2;
  localparam logic [WA-1:0] BASE_W = WA'(BASE_ADDR >> 2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Address decode: wrap-around subtraction folds the lower bound into one compare
  logic [WA-1:0] word_off;
  logic          hit;
  logic [2:0]    reg_sel;
  assign word_off = ahb_addr[ADDRWIDTH-1:2] - BASE_W;
  assign hit      = word_off < WA'(8);
  assign reg_sel  = word_off[2:0];

  logic [31:0] wmask, wd;
  assign wmask = {{8{ahb_byte_strobe[3]}}, {8{ahb_byte_strobe[2]}},
                  {8{ahb_byte_strobe[1]}}, {8{ahb_byte_strobe[0]}}};
  assign wd    = ahb_wdata & wmask;

  logic wr_do, wr_set, wr_clr, wr_oe, wr_st, wr_en, wr_cr;
  assign wr_do  = ahb_write_en && hit && (reg_sel == 3'd0);
  assign wr_set = ahb_write_en && hit && (reg_sel == 3'd1);
  assign wr_clr = ahb_write_en && hit && (reg_sel == 3'd2);
  assign wr_oe  = ahb_write_en && hit && (reg_sel == 3'd3);
  assign wr_st  = ahb_write_en && hit && (reg_sel == 3'd5);
  assign wr_en  = ahb_write_en && hit && (reg_sel == 3'd6);
  assign wr_cr  = ahb_write_en && hit && (reg_sel == 3'd7);

  logic [G-1:0]       do_r, oe_r, rise_st, fall_st, rise_en, fall_en;
  logic [3:0]         cr_ch;
  logic               cr_lvl;
  logic [PULSE_W-1:0] cr_width;
  state_t             state;
  logic [PULSE_W-1:0] cnt;
  logic [3:0]         p_ch;
  logic               p_lvl;

  // PULSE_CR fields as they will be after this cycle's write
  logic [3:0]         ch_new;
  logic               lvl_new;
  logic [15:0]        cr16, width16_new;
  logic [PULSE_W-1:0] width_new;
  logic               start_c;
  assign cr16        = 16'(cr_width);
  assign ch_new      = (wr_cr && ahb_byte_strobe[0]) ? ahb_wdata[3:0] : cr_ch;
  assign lvl_new     = (wr_cr && ahb_byte_strobe[0]) ? ahb_wdata[4] : cr_lvl;
  assign width16_new = {(wr_cr && ahb_byte_strobe[3]) ? ahb_wdata[31:24] : cr16[15:8],
                        (wr_cr && ahb_byte_strobe[2]) ? ahb_wdata[23:16] : cr16[7:0]};
  assign width_new   = PULSE_W'(width16_new);
  assign start_c     = wr_cr && ahb_byte_strobe[1] && ahb_wdata[8] &&
                       ({1'b0, ch_new} < 5'(G));

  // Input synchroniser and edge detect
  logic [G-1:0] sync_q [SYNC_STAGES];
  logic [G-1:0] di, di_d, rise_c, fall_c;
  assign di     = sync_q[SYNC_STAGES-1];
  assign rise_c = di & ~di_d;
  assign fall_c = ~di & di_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      di_d <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      di_d <= di;
    end
  end

  logic [G-1:0] w1c_r, w1c_f;
  assign w1c_r = wr_st ? wd[G-1:0] : '0;
  assign w1c_f = wr_st ? wd[16+G-1:16] : '0;

  // Register bank; a hardware edge wins over a same-cycle W1C
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      do_r     <= '0;
      oe_r     <= '0;
      rise_st  <= '0;
      fall_st  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      cr_ch    <= '0;
      cr_lvl   <= 1'b0;
      cr_width <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_do)  do_r <= (do_r & ~wmask[G-1:0]) | wd[G-1:0];
      if (wr_set) do_r <= do_r | wd[G-1:0];
      if (wr_clr) do_r <= do_r & ~wd[G-1:0];
      if (wr_oe)  oe_r <= (oe_r & ~wmask[G-1:0]) | wd[G-1:0];
      if (wr_en) begin
        rise_en <= (rise_en & ~wmask[G-1:0]) | wd[G-1:0];
        fall_en <= (fall_en & ~wmask[16+G-1:16]) | wd[16+G-1:16];
      end
      rise_st  <= (rise_st & ~w1c_r) | rise_c;
      fall_st  <= (fall_st & ~w1c_f) | fall_c;
      cr_ch    <= ch_new;
      cr_lvl   <= lvl_new;
      cr_width <= width_new;
      irq      <= |((rise_st & rise_en) | (fall_st & fall_en));
    end
  end

  // Pulse generator: override lasts exactly 'width' cycles after the START write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      p_ch  <= '0;
      p_lvl <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            state <= ACTIVE;
            p_ch  <= ch_new;
            p_lvl <= lvl_new;
            cnt   <= (width_new == '0) ? PULSE_W'(1) : width_new;
          end
        end
        ACTIVE: begin
          if (cnt == PULSE_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - PULSE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic         busy;
  logic [G-1:0] pmask;
  assign busy    = (state == ACTIVE);
  assign pmask   = busy ? (G'(1) << p_ch) : '0;
  assign gpio_o  = (do_r & ~pmask) | ({G{p_lvl}} & pmask);
  assign gpio_oe = oe_r | pmask;

  always_comb begin
    ahb_rdata = '0;
    if (hit) begin
      case (reg_sel)
        3'd0:    ahb_rdata = 32'(do_r);
        3'd3:    ahb_rdata = 32'(oe_r);
        3'd4:    ahb_rdata = 32'(di);
        3'd5:    ahb_rdata = {16'(fall_st), 16'(rise_st)};
        3'd6:    ahb_rdata = {16'(fall_en), 16'(rise_en)};
        3'd7:    ahb_rdata = {cr16, 6'd0, busy, 1'b0, 3'd0, cr_lvl, cr_ch};
        default: ahb_rdata = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ahb_addr[1:0], ahb_wdata};

endmodule

// File: tb/tb_dap_gpio_bank.sv
// Directed self-checking bench for dap_gpio_bank (default parameters, 8 pins).
module tb_dap_gpio_bank;

  logic        clk;
  logic        resetn;
  logic        ahb_write_en;
  logic [11:0] ahb_addr;
  logic [31:0] ahb_wdata;
  logic [3:0]  ahb_byte_strobe;
  logic [31:0] ahb_rdata;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] A_DO = 12'h000, A_SET = 12'h004, A_CLR = 12'h008, A_OE = 12'h00C,
                          A_DI = 12'h010, A_ST = 12'h014, A_EN = 12'h018, A_CR = 12'h01C;

  dap_gpio_bank dut (
    .clk(clk), .resetn(resetn), .ahb_write_en(ahb_write_en), .ahb_addr(ahb_addr),
    .ahb_wdata(ahb_wdata), .ahb_byte_strobe(ahb_byte_strobe), .ahb_rdata(ahb_rdata),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    ahb_addr = addr;
    #1;
    check(tag, ahb_rdata, exp);
  endtask

  task automatic bus_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    ahb_write_en    = 1'b1;
    ahb_addr        = addr;
    ahb_wdata       = data;
    ahb_byte_strobe = strb;
    @(posedge clk);
    #1;
    ahb_write_en    = 1'b0;
    ahb_byte_strobe = 4'h0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; ahb_write_en = 1'b0; ahb_addr = '0; ahb_wdata = '0;
    ahb_byte_strobe = '0; gpio_i = '0;
    #25;
    // Reset state
    rd_check("rst_do", A_DO, 0);   rd_check("rst_set", A_SET, 0);
    rd_check("rst_clr", A_CLR, 0); rd_check("rst_oe", A_OE, 0);
    rd_check("rst_di", A_DI, 0);   rd_check("rst_st", A_ST, 0);
    rd_check("rst_en", A_EN, 0);   rd_check("rst_cr", A_CR, 0);
    check("rst_pins", {gpio_oe, gpio_o}, 0);
    check("rst_irq", 32'(irq), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Output data set/clear
    bus_write(A_OE, 32'hFF, 4'hF);
    bus_write(A_DO, 32'h05, 4'hF);
    check("do_write", 32'(gpio_o), 32'h05);
    bus_write(A_SET, 32'h02, 4'hF);
    check("do_set", 32'(gpio_o), 32'h07);
    bus_write(A_CLR, 32'h04, 4'hF);
    check("do_clr", 32'(gpio_o), 32'h03);
    rd_check("do_read", A_DO, 32'h03);
    rd_check("set_reads0", A_SET, 0);
    bus_write(A_DO, 32'hFF, 4'b0010);
    rd_check("do_strobe_gated", A_DO, 32'h03);
    rd_check("unmapped_20", 12'h020, 0);
    rd_check("unmapped_ffc", 12'hFFC, 0);
    bus_write(A_EN, 32'hFFFF_FFFF, 4'b0100);
    rd_check("en_lane2", A_EN, 32'h00FF_0000);
    bus_write(A_EN, 32'h0000_0001, 4'hF);

    // Rising edge -> DI -> EDGE_ST -> irq, then W1C
    @(negedge clk); gpio_i = 8'h01;
    tick(); rd_check("di_lat1", A_DI, 0);
    tick(); rd_check("di_lat2", A_DI, 1); rd_check("st_before", A_ST, 0);
    tick(); rd_check("st_rise", A_ST, 1); check("irq_before", 32'(irq), 0);
    tick(); check("irq_set", 32'(irq), 1);
    bus_write(A_ST, 32'h1, 4'hF);
    check("irq_hold", 32'(irq), 1);
    rd_check("st_cleared", A_ST, 0);
    tick(); check("irq_clear", 32'(irq), 0);

    // Falling edge sets fall flag, not irq
    @(negedge clk); gpio_i = 8'h00;
    repeat (4) tick();
    rd_check("st_fall", A_ST, 32'h0001_0000);
    check("irq_fall_masked", 32'(irq), 0);
    bus_write(A_ST, 32'hFFFF_FFFF, 4'hF);
    rd_check("st_all_clr", A_ST, 0);

    // Rise on the same edge as W1C keeps the flag
    @(negedge clk); gpio_i = 8'h01;
    @(posedge clk); @(posedge clk);
    bus_write(A_ST, 32'h1, 4'hF);
    rd_check("st_set_wins", A_ST, 32'h1);
    bus_write(A_EN, 32'h0, 4'hF);
    bus_write(A_ST, 32'hFFFF_FFFF, 4'hF);
    rd_check("st_final_clr", A_ST, 0);

    // Pulse ch3 level0 width10 with DO[3]=1, OE[3]=0
    bus_write(A_DO, 32'h0B, 4'hF);
    bus_write(A_OE, 32'hF7, 4'hF);
    check("pins_pre", {gpio_oe, gpio_o}, 32'hF70B);
    bus_write(A_CR, 32'h000A_0103, 4'hF);
    check("pulse_c0", {gpio_oe, gpio_o}, 32'hFF03);
    rd_check("busy_set", A_CR, 32'h000A_0203);
    for (int i = 1; i < 10; i++) begin
      if (i == 4) bus_write(A_CR, 32'h0005_0111, 4'hF);
      else tick();
      check($sformatf("pulse_c%0d", i), {gpio_oe, gpio_o}, 32'hFF03);
    end
    rd_check("cr_fields_upd", A_CR, 32'h0005_0211);
    tick();
    check("pulse_end", {gpio_oe, gpio_o}, 32'hF70B);
    rd_check("busy_clr", A_CR, 32'h0005_0011);

    // Width 0 gives one cycle
    bus_write(A_CR, 32'h0000_0103, 4'hF);
    check("w0_on", {gpio_oe, gpio_o}, 32'hFF03);
    rd_check("w0_busy", A_CR, 32'h0000_0203);
    tick();
    check("w0_off", {gpio_oe, gpio_o}, 32'hF70B);

    // Out-of-range channel ignored
    bus_write(A_CR, 32'h0010_010C, 4'hF);
    check("ch12_pins", {gpio_oe, gpio_o}, 32'hF70B);
    rd_check("ch12_nobusy", A_CR, 32'h0010_000C);
    bus_write(A_DO, 32'hFFFF_FFFF, 4'hF);
    rd_check("do_upper_zero", A_DO, 32'hFF);

    // Reset in the middle of a pulse
    bus_write(A_CR, 32'h000A_0103, 4'hF);
    repeat (3) tick();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_pins", {gpio_oe, gpio_o}, 0);
    rd_check("rst_mid_cr", A_CR, 0);
    @(negedge clk); resetn = 1'b1;
    tick();
    check("post_rst_pins", {gpio_oe, gpio_o}, 0);
    rd_check("post_rst_busy", A_CR, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dap_gpio_bank.md
Name: dap_gpio_bank

Overview:
Parametrised GPIO bank for the DAP controller: GPIO_NUM general-purpose pins, each with output-data and output-enable registers, synchronised input sampling, edge detection with sticky status and an interrupt, and one hardware pulse generator. The pulse generator produces timed pulses on a selected pin, for example an SRST or TRST assertion of a defined length. The block is mapped on the controller's AHB memory-style register bus and sits between the DAP command engine and the connector pins.

Parameters:
ADDRWIDTH, 12, register bus address width
BASE_ADDR, 0, byte base address of the register window (word-aligned)
GPIO_NUM, 8, number of pins, 1..16
SYNC_STAGES, 2, input synchroniser depth, 2..4
PULSE_W, 16, pulse width counter bits, at most 16

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
ahb_write_en  in  1  register write strobe, one cycle per write
ahb_addr  in  ADDRWIDTH  byte address; decode uses bits [ADDRWIDTH-1:2]
ahb_wdata  in  32  write data
ahb_byte_strobe  in  4  byte lane enables
ahb_rdata  out  32  read data, combinational from ahb_addr
gpio_i  in  GPIO_NUM  pin inputs, asynchronous
gpio_o  out  GPIO_NUM  pin output values
gpio_oe  out  GPIO_NUM  pin output enables, 1 = drive
irq  out  1  level interrupt, registered

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: every register is 0, so gpio_o = 0, gpio_oe = 0 and irq = 0. The pulse generator is IDLE with its counter at 0. Synchroniser flops reset to 0.
- Register map, as word offsets from BASE_ADDR:
  - +0x00 DO (RW): output data.
  - +0x04 DO_SET (W): 1 bits are ORed into DO.
  - +0x08 DO_CLR (W): 1 bits are cleared in DO.
  - +0x0C OE (RW): output enables.
  - +0x10 DI (R): synchronised inputs.
  - +0x14 EDGE_ST (R/W1C): [15:0] rise flags, [31:16] fall flags.
  - +0x18 IRQ_EN (RW): [15:0] rise enables, [31:16] fall enables.
  - +0x1C PULSE_CR: [3:0] channel, [4] level, [8] START (W, self-clearing), [9] BUSY (R), [31:16] width.
- Bus access rules:
  - Unused bits read 0 and ignore writes.
  - Unmapped addresses read 0.
  - Byte strobes gate each byte lane individually.
  - DO_SET and DO_CLR read 0.
  - A write takes effect at the next clk edge. A read returns the current state combinationally.
- Input path:
  - gpio_i passes through SYNC_STAGES flops to form DI, plus one more flop to form DI_d.
  - rise = DI & ~DI_d; fall = ~DI & DI_d.
  - Input-to-DI latency is SYNC_STAGES cycles. The edge flag sets one cycle later.
- EDGE_ST flags are sticky:
  - next = (cur & ~w1c_mask) | new_edge, so a hardware set wins over a same-cycle W1C.
  - irq is registered: irq <= |(EDGE_ST & IRQ_EN). It deasserts one cycle after the clearing write.
- Pulse generator FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on a write to PULSE_CR with strobe[1] set, wdata[8] = 1 and channel < GPIO_NUM.
  - On entry the block latches channel, level, and width. A width of 0 is loaded as 1.
  - A start while ACTIVE, or with an out-of-range channel, is ignored. The other PULSE_CR fields still update.
  - In ACTIVE: gpio_o[ch] = level and gpio_oe[ch] = 1. All other pins follow DO/OE.
  - The counter decrements each cycle and returns to IDLE when it reaches 1. The override lasts exactly width cycles, starting the cycle after the START write.
  - BUSY = (state == ACTIVE).
  - DO/OE writes during ACTIVE update the registers without interrupting the pulse. The pin shows the new DO/OE values after the pulse ends.
- Outputs when no pulse is active: gpio_o = DO and gpio_oe = OE, driven from registers with no combinational path from the bus.
- Reset mid-pulse: the FSM returns to IDLE immediately and the pins drop to 0 asynchronously.
- Channels at or above GPIO_NUM: DO, OE, DI and EDGE_ST bits read 0 and ignore writes.

Test Plan:
1. Reset, then read every register -> all read 0; gpio_o = 0, gpio_oe = 0, irq = 0.
2. Write DO = 0x05, then DO_SET = 0x02, then DO_CLR = 0x04, with OE = 0xFF -> gpio_o shows 0x05, then 0x07, then 0x03, each one cycle after its write.
3. With IRQ_EN = 0x0000_0001, raise gpio_i[0] -> DI[0] = 1 after 2 cycles, EDGE_ST[0] = 1 one cycle later, irq = 1 one cycle after that. W1C 0x1 -> irq = 0 one cycle later. A rise on the same cycle as the W1C leaves the flag set.
4. Write PULSE_CR with channel = 3, level = 0, width = 10, START = 1 while DO[3] = 1 and OE[3] = 0 -> gpio_oe[3] = 1 and gpio_o[3] = 0 for exactly 10 cycles; BUSY = 1 throughout; the pin then reverts to oe = 0. A second START during the pulse is ignored.
5. START with width = 0 -> a 1-cycle pulse. START with channel = 12 on GPIO_NUM = 8 -> no pulse, BUSY stays 0.
6. Assert resetn low during an ACTIVE pulse -> gpio_o and gpio_oe go to 0 immediately; after release BUSY = 0.
